hc_sr_echo: RTL and testbench
=============================

// Module: hc_sr_echo
// PURPOSE
//  Receive side of the HC-SR04 ultrasonic ranging interface. Arms on the falling edge of the
//  10-15 us trig pulse, measures the echo-high time in microseconds, and converts it to
//  distance in millimetres. Sits beside the trigger generator on the 1 MHz clk_us domain and
//  feeds the display/UART path with one result per ranging cycle.
// PARAMETERS
//  WAIT_MAX  16'd5000   max us from arm to echo rising edge before timeout
//  ECHO_MAX  16'd25000  max echo-high us (~4.3 m) before timeout
//  K_MUL     16'd11239  distance scale numerator (0.1715 mm/us * 2^K_SHIFT)
//  K_SHIFT   5'd16      distance scale right shift
// PORTS
//  clk_us       in   1   1 MHz clock; one cycle = 1 us
//  Rst_n        in   1   asynchronous reset, active low
//  trig         in   1   trigger pulse from trigger generator (same clock domain)
//  echo         in   1   sensor echo pin, asynchronous
//  busy         out  1   high in any state other than IDLE
//  dist_mm      out  16  last distance, mm; 16'hFFFF after a timeout
//  dist_valid   out  1   one-cycle pulse: dist_mm updated with a good measurement
//  timeout_err  out  1   one-cycle pulse: measurement aborted, dist_mm = 16'hFFFF
// BEHAVIOUR
//  - Reset values: busy=0, dist_mm=0, dist_valid=0, timeout_err=0, state=IDLE, counter=0.
//  - echo passes a 2-FF synchronizer (echo_s); edges come from echo_s vs. its previous value.
//  - trig falling edge is detected from a registered copy of trig.
//  - FSM (all transitions on clk_us):
//    IDLE     : on trig fall -> WAIT_HI, cnt<=0. Otherwise stay.
//    WAIT_HI  : cnt++ each cycle. echo_s rise -> MEASURE, cnt<=1.
//               cnt reaching WAIT_MAX-1 with no rise -> TIMEOUT.
//               If echo_s is already high on arm, wait for a low followed by a rise.
//    MEASURE  : cnt++ while echo_s high. echo_s fall -> CALC, cnt is held.
//               cnt reaching ECHO_MAX with echo_s still high -> TIMEOUT.
//    CALC     : prod <= cnt * K_MUL (32-bit unsigned, registered) -> DONE.
//    DONE     : dist_mm <= prod >> K_SHIFT (low 16 bits), dist_valid=1 for one cycle -> IDLE.
//    TIMEOUT  : dist_mm <= 16'hFFFF, timeout_err=1 for one cycle -> IDLE.
//  - Measured count = number of clk_us cycles echo_s is sampled high (+/-1 us vs. pin width).
//  - Latency: dist_valid is asserted exactly 2 cycles after the cycle in which the echo_s
//    falling edge is detected.
//  - trig edges outside IDLE are ignored; no re-arm until IDLE is reached.
//  - dist_valid and timeout_err never assert in the same cycle. dist_mm holds between updates.
//  - Rst_n low at any time, including mid-measure, returns every register to its reset
//    value immediately. No partial result is emitted.
//  - Arithmetic is unsigned. cnt is 16 bits and cannot wrap because ECHO_MAX < 2^16.
// STRUCTURE
//  - Shared package hc_sr_pkg: FSM state encoding (IDLE, WAIT_HI, MEASURE, CALC, DONE,
//    TIMEOUT) and the default K_MUL/K_SHIFT and timeout constants, shared with the trigger
//    module and the top level.
//  - One sub-module, hc_sr_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs, reset
//    by Rst_n. It is instantiated for echo. trig uses a plain edge register.
//  - FSM, counter, multiply register and output registers live in hc_sr_echo.
// TESTING
//  1. Reset, then trig pulse of 15 us, echo high 580 us after a 400 us delay
//     -> dist_valid pulse, dist_mm=99 ((580*11239)>>16), busy falls in the same cycle.
//  2. Echo high 1000 us -> dist_mm=171. Echo high 1 us -> dist_mm=0 with dist_valid.
//  3. trig with echo held low -> timeout_err after WAIT_MAX us, dist_mm=16'hFFFF,
//     no dist_valid.
//  4. Echo held high 30000 us -> timeout_err when cnt reaches ECHO_MAX, dist_mm=16'hFFFF.
//     Echo falling later causes no output.
//  5. Rst_n asserted 200 us into MEASURE -> all outputs 0 at once, busy=0.
//     After release, a normal 580 us cycle -> dist_mm=99.
//  6. Second trig during MEASURE -> ignored, exactly one dist_valid.
//     Echo already high at arm then low then high 580 us -> dist_mm=99.

Source files
------------

// File: rtl/hc_sr_pkg.sv
// Shared definitions for the HC-SR04 ranging path: FSM encoding and default constants.
package hc_sr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_HI = 3'd1,
        ST_MEASURE = 3'd2,
        ST_CALC    = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } hc_sr_state_e;

    // Longest wait from arm to echo rise, in us.
    localparam logic [15:0] WAIT_MAX_DEF = 16'd5000;
    // Longest echo-high time, in us (~4.3 m).
    localparam logic [15:0] ECHO_MAX_DEF = 16'd25000;
    // 0.1715 mm/us scaled by 2^16.
    localparam logic [15:0] K_MUL_DEF    = 16'd11239;
    localparam logic [4:0]  K_SHIFT_DEF  = 5'd16;

endpackage

// File: rtl/hc_sr_echo_if.sv
// Trigger/echo inputs and result outputs of the echo receiver.
interface hc_sr_echo_if;
    import hc_sr_pkg::*;

    logic        trig;
    logic        echo;
    logic        busy;
    logic [15:0] dist_mm;
    logic        dist_valid;
    logic        timeout_err;

    // Driver side: trigger generator / sensor pin and result consumer.
    modport master (
        output trig, echo,
        input  busy, dist_mm, dist_valid, timeout_err
    );

    // Echo receiver side.
    modport slave (
        input  trig, echo,
        output busy, dist_mm, dist_valid, timeout_err
    );

endinterface

// File: rtl/hc_sr_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with rise/fall pulses on the synced copy.
module hc_sr_sync_edge (
    input  logic clk_us,
    input  logic Rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    // Shift the pin through two sync stages and keep one more copy for edge detection.
    always_ff @(posedge clk_us or negedge Rst_n) begin
        if (!Rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/hc_sr_echo.sv
// HC-SR04 echo receiver: arms on trig fall, times echo high in us, scales to mm.
module hc_sr_echo
    import hc_sr_pkg::*;
#(
    parameter logic [15:0] WAIT_MAX = WAIT_MAX_DEF,
    parameter logic [15:0] ECHO_MAX = ECHO_MAX_DEF,
    parameter logic [15:0] K_MUL    = K_MUL_DEF,
    parameter logic [4:0]  K_SHIFT  = K_SHIFT_DEF
) (
    input  logic         clk_us,
    input  logic         Rst_n,
    hc_sr_echo_if.slave  sr_if
);

    hc_sr_state_e state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [31:0]  prod_q, prod_d;
    logic [15:0]  dist_q, dist_d;
    logic [31:0]  prod_sh;
    logic         trig_q, trig_fall;
    logic         echo_s, echo_rise, echo_fall;

    hc_sr_sync_edge u_echo_sync (
        .clk_us  (clk_us),
        .Rst_n   (Rst_n),
        .async_i (sr_if.echo),
        .sync_o  (echo_s),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    // trig is already in this clock domain, so one register is enough for its edge.
    always_ff @(posedge clk_us or negedge Rst_n) begin
        if (!Rst_n) trig_q <= 1'b0;
        else        trig_q <= sr_if.trig;
    end

    assign trig_fall = trig_q & ~sr_if.trig;
    assign prod_sh   = prod_q >> K_SHIFT;

    // State, counter, product and held-result registers.
    always_ff @(posedge clk_us or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            dist_q  <= dist_d;
        end
    end

    // Next state and datapath updates; a rise only counts once echo_s has been low,
    // which covers an echo that is already high when the FSM arms.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        dist_d  = dist_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_fall) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HI: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = 16'd1;
                end else if (cnt_q == WAIT_MAX - 16'd1) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_MEASURE: begin
                if (echo_fall) begin
                    state_d = ST_CALC;
                end else if (echo_s && (cnt_q == ECHO_MAX)) begin
                    state_d = ST_TIMEOUT;
                end else if (echo_s) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CALC: begin
                prod_d  = 32'(cnt_q) * 32'(K_MUL);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                dist_d  = prod_sh[15:0];
                state_d = ST_IDLE;
            end
            ST_TIMEOUT: begin
                dist_d  = 16'hFFFF;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: dist_mm shows the new value in the same cycle as its strobe and holds after.
    always_comb begin
        sr_if.busy        = (state_q != ST_IDLE);
        sr_if.dist_valid  = (state_q == ST_DONE);
        sr_if.timeout_err = (state_q == ST_TIMEOUT);
        sr_if.dist_mm     = dist_d;
    end

endmodule

// File: tb/tb_hc_sr_echo.sv
// Randomized bench for hc_sr_echo against a pulse-width -> millimetre model.
module tb_hc_sr_echo;

    localparam int WAIT_MAX = 5000;
    localparam int ECHO_MAX = 25000;
    localparam int K_MUL    = 11239;
    localparam int K_DIV    = 65536;
    // 2 synchronizer stages + fall-to-strobe latency of 2.
    localparam int LAT      = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hc_sr_echo_if bus ();

    hc_sr_echo dut (
        .clk_us (clk),
        .Rst_n  (rst_n),
        .sr_if  (bus)
    );

    int n_chk = 0, n_pass = 0;
    int nv = 0, nto = 0, nboth = 0;
    logic [15:0] last_v = '0, last_t = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Expected distance from the number of us echo is high.
    function automatic logic [15:0] model(input int w);
        longint p;
        if (w > ECHO_MAX) return 16'hFFFF;
        p = (longint'(w) * K_MUL) / K_DIV;
        return 16'(p);
    endfunction

    // Result strobe bookkeeping.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dist_valid)  begin nv++;  last_v = bus.dist_mm; end
            if (bus.timeout_err) begin nto++; last_t = bus.dist_mm; end
            if (bus.dist_valid && bus.timeout_err) nboth++;
        end
    end

    task automatic trig_pulse();
        @(negedge clk);
        bus.trig = 1'b1;
        repeat (15) @(negedge clk);
        bus.trig = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.dist_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One ranging cycle that should produce a good result. With pre set, echo is high
    // before the trigger and drops 50 us after arm before the real pulse.
    task automatic good_shot(input string tag, input int dly, input int w, input bit pre);
        int v0, t0, lat;
        v0 = nv; t0 = nto;
        if (pre) bus.echo = 1'b1;
        trig_pulse();
        if (pre) begin
            repeat (50) @(negedge clk);
            bus.echo = 1'b0;
        end
        repeat (dly) @(negedge clk);
        bus.echo = 1'b1;
        repeat (w) @(negedge clk);
        bus.echo = 1'b0;
        wait_valid(lat);
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_dist"}, bus.dist_mm, model(w));
        @(negedge clk);
        chk({tag, "_busy_after"}, bus.busy, 1'b0);
        chk({tag, "_valid_after"}, bus.dist_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk({tag, "_nvalid"}, nv - v0, 1);
        chk({tag, "_nto"}, nto - t0, 0);
        chk({tag, "_hold"}, bus.dist_mm, model(w));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int v0, t0, lat, w, d;
        bus.trig = 1'b0;
        bus.echo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_dist", bus.dist_mm, 16'd0);
        chk("rst_valid", bus.dist_valid, 1'b0);
        chk("rst_to", bus.timeout_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);

        // Basic distances and the 1 us minimum.
        good_shot("t1", 400, 580, 1'b0);
        good_shot("t2a", 100, 1000, 1'b0);
        good_shot("t2b", 30, 1, 1'b0);

        // No echo at all: wait-for-echo timeout.
        v0 = nv; t0 = nto;
        trig_pulse();
        lat = 0;
        while (!bus.timeout_err && lat < WAIT_MAX + 50) begin
            @(negedge clk);
            lat++;
        end
        chk("t3_lat_in_window", (lat >= WAIT_MAX && lat <= WAIT_MAX + 2), 1'b1);
        chk("t3_dist", bus.dist_mm, 16'hFFFF);
        repeat (5) @(negedge clk);
        chk("t3_nto", nto - t0, 1);
        chk("t3_nvalid", nv - v0, 0);
        chk("t3_busy", bus.busy, 1'b0);

        // Echo stuck high: echo-length timeout, late fall ignored.
        v0 = nv; t0 = nto;
        trig_pulse();
        repeat (20) @(negedge clk);
        bus.echo = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30000; i++) begin
            @(negedge clk);
            if (bus.timeout_err && lat == 0) lat = i;
        end
        bus.echo = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_lat_in_window", (lat >= ECHO_MAX && lat <= ECHO_MAX + 4), 1'b1);
        chk("t4_nto", nto - t0, 1);
        chk("t4_nvalid", nv - v0, 0);
        chk("t4_dist", last_t, 16'hFFFF);
        chk("t4_hold", bus.dist_mm, 16'hFFFF);

        // Reset 200 us into the measurement.
        v0 = nv; t0 = nto;
        trig_pulse();
        repeat (50) @(negedge clk);
        bus.echo = 1'b1;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_dist", bus.dist_mm, 16'd0);
        chk("t5_valid", bus.dist_valid, 1'b0);
        chk("t5_to", bus.timeout_err, 1'b0);
        @(negedge clk);
        bus.echo = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_no_partial", (nv - v0) + (nto - t0), 0);
        good_shot("t5b", 400, 580, 1'b0);

        // Second trig during measurement is ignored.
        v0 = nv; t0 = nto;
        trig_pulse();
        repeat (30) @(negedge clk);
        bus.echo = 1'b1;
        repeat (100) @(negedge clk);
        bus.trig = 1'b1;
        repeat (15) @(negedge clk);
        bus.trig = 1'b0;
        repeat (465) @(negedge clk);
        bus.echo = 1'b0;
        wait_valid(lat);
        chk("t6a_lat", lat, LAT);
        chk("t6a_dist", bus.dist_mm, 16'd99);
        repeat (WAIT_MAX + 100) @(negedge clk);
        chk("t6a_nvalid", nv - v0, 1);
        chk("t6a_nto", nto - t0, 0);

        // Echo already high at arm.
        good_shot("t6b", 40, 580, 1'b1);

        // Random delays and widths.
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(1, 2000);
            w = $urandom_range(1, 2500);
            good_shot($sformatf("rnd%0d_w%0d", i, w), d, w, 1'(i % 2));
        end

        chk("no_overlap", nboth, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
